// File: rtl/verinject_schedule_injector.sv
// verinject_schedule_injector: cycle counter plus in-order event queue that drives the one-cycle injection-select word.
module verinject_schedule_injector #(
   parameter int DEPTH = 16
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         load_valid,
   output logic                         load_ready,
   input  logic [47:0]                  load_cycle,
   input  logic [31:0]                  load_bit,
   output logic [47:0]                  cycle_number,
   output logic [31:0]                  verinject__injector_state,
   output logic [$clog2(DEPTH+1)-1:0]   pending_count,
   output logic                         overrun,
   output logic                         load_error
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [47:0] CYC_MAX = '1;
   localparam logic [31:0] IDLE = 32'hFFFF_FFFF;
   localparam logic [31:0] RST = 32'hFFFF_FFFE;
   logic [47:0] ev_cycle [DEPTH];
   logic [31:0] ev_bit [DEPTH];
   logic [AW-1:0] head, tail;
   logic [47:0] next_cycle;
   logic reserved, accept, store, nonempty, hit, late, pop;
   always_comb begin
      next_cycle = (cycle_number == CYC_MAX) ? cycle_number : cycle_number + 48'd1;
      reserved = (load_bit == IDLE) || (load_bit == RST);
      accept = load_valid && load_ready;
      store = accept && !reserved;
      nonempty = pending_count != '0;
      hit = nonempty && (ev_cycle[head] == next_cycle);
      late = nonempty && (ev_cycle[head] < next_cycle);
      pop = hit || late;
   end
   // readiness follows the pre-edge count only, so a same-cycle pop never frees space early
   assign load_ready = pending_count != CW'(DEPTH);
   always_ff @(posedge clock) begin
      if (reset) begin
         cycle_number <= '0;
         verinject__injector_state <= RST;
         head <= '0;
         tail <= '0;
         pending_count <= '0;
         overrun <= 1'b0;
         load_error <= 1'b0;
      end else begin
         cycle_number <= next_cycle;
         verinject__injector_state <= hit ? ev_bit[head] : IDLE;
         if (store) tail <= tail + AW'(1);
         if (pop) head <= head + AW'(1);
         pending_count <= pending_count + CW'(store) - CW'(pop);
         overrun <= overrun || late;
         load_error <= load_error || (accept && reserved);
      end
   end
   always_ff @(posedge clock) begin
      if (store) begin
         ev_cycle[tail] <= load_cycle;
         ev_bit[tail] <= load_bit;
      end
   end
endmodule
